// File: rtl/i2c_bus_scheduler.sv
// i2c_bus_scheduler: round-robin sharing of one i2c_master between NUM_REQ requesters with timeouts and idle gap.
// Optional slot-0 auto-poll is enabled by defining I2C_SCHED_AUTOPOLL_EN.
module i2c_bus_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int LAUNCH_TIMEOUT = 4096,
  parameter int RUN_TIMEOUT    = 1000000,
  parameter int GAP_CYCLES     = 256,
  parameter int POLL_PERIOD    = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [7*NUM_REQ-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]      req_rw,
  input  logic [5*NUM_REQ-1:0]    req_bytes,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      done,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    m_start,
  output logic [6:0]              m_addr,
  output logic                    m_rw,
  output logic [4:0]              m_bytes,
  output logic [31:0]             m_data_out,
  input  logic                    m_busy,
  input  logic                    m_valid,
  input  logic [31:0]             m_data_in
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int LW = $clog2(LAUNCH_TIMEOUT + 1);
  localparam int RW = $clog2(RUN_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LAUNCH, S_RUN, S_FINISH, S_GAP} state_t;
  state_t r_state;
  logic r_busy_s1, r_busy_s2, r_valid_s1, r_valid_s2, r_to;
  logic [IW-1:0] r_ptr, r_grant;
  logic [LW-1:0] r_lcnt;
  logic [RW-1:0] r_rcnt;
  logic [GW-1:0] r_gcnt;
  logic [NUM_REQ-1:0] w_req;
  logic [IW-1:0] w_grant;
  logic w_found;
  logic [4:0] w_bytes;
  logic [31:0] w_mask;
  // busy synchroniser resets high so a master left running by a reset blocks arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_s1  <= 1'b1;
      r_busy_s2  <= 1'b1;
      r_valid_s1 <= 1'b0;
      r_valid_s2 <= 1'b0;
    end else begin
      r_busy_s1  <= m_busy;
      r_busy_s2  <= r_busy_s1;
      r_valid_s1 <= m_valid;
      r_valid_s2 <= r_valid_s1;
    end
  end
`ifdef I2C_SCHED_AUTOPOLL_EN
  localparam int PW = $clog2(POLL_PERIOD + 1);
  logic [PW-1:0] r_pcnt;
  logic r_pend;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pcnt <= (r_pcnt == PW'(POLL_PERIOD - 1)) ? '0 : r_pcnt + 1'b1;
      if (done[0]) r_pend <= 1'b0;
      if (r_pcnt == PW'(POLL_PERIOD - 1)) r_pend <= 1'b1;
    end
  end
  assign w_req = req | NUM_REQ'(r_pend);
`else
  assign w_req = req;
`endif
  // descending scan so the last hit is the first set bit at or after the pointer
  always_comb begin
    w_grant = r_ptr;
    w_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_grant = IW'((int'(r_ptr) + i) % NUM_REQ);
        w_found = 1'b1;
      end
    end
  end
  assign w_bytes = req_bytes[int'(w_grant)*5 +: 5];
  assign w_mask  = (m_bytes >= 5'd4) ? '1 : (32'd1 << {m_bytes, 3'b000}) - 32'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_to       <= 1'b0;
      r_lcnt     <= '0;
      r_rcnt     <= '0;
      r_gcnt     <= '0;
      done       <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      m_start    <= 1'b0;
      m_addr     <= '0;
      m_rw       <= 1'b0;
      m_bytes    <= '0;
      m_data_out <= '0;
    end else begin
      done <= '0;
      case (r_state)
        S_IDLE: if (|w_req && !r_busy_s2) r_state <= S_ARB;
        S_ARB: begin
          if (!w_found) r_state <= S_IDLE;
          else begin
            r_grant    <= w_grant;
            m_addr     <= req_addr[int'(w_grant)*7 +: 7];
            m_rw       <= req_rw[w_grant];
            m_bytes    <= w_bytes;
            m_data_out <= req_data[int'(w_grant)*32 +: 32];
            r_ptr      <= (w_grant == IW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
            r_to       <= 1'b0;
            r_lcnt     <= '0;
            r_gcnt     <= '0;
            if (w_bytes > 5'd4) begin
              done[w_grant] <= 1'b1;
              rsp_err       <= 1'b1;
              rsp_data      <= '0;
              r_state       <= S_GAP;
            end else begin
              m_start <= 1'b1;
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (r_busy_s2) begin
            m_start <= 1'b0;
            r_rcnt  <= '0;
            r_state <= S_RUN;
          end else if (r_lcnt == LW'(LAUNCH_TIMEOUT - 1)) begin
            m_start <= 1'b0;
            r_to    <= 1'b1;
            r_state <= S_FINISH;
          end else r_lcnt <= r_lcnt + 1'b1;
        end
        S_RUN: begin
          if (!r_busy_s2) r_state <= S_FINISH;
          else if (r_rcnt == RW'(RUN_TIMEOUT - 1)) begin
            r_to    <= 1'b1;
            r_state <= S_FINISH;
          end else r_rcnt <= r_rcnt + 1'b1;
        end
        S_FINISH: begin
          done[r_grant] <= 1'b1;
          rsp_data      <= m_rw ? (m_data_in & w_mask) : '0;
          rsp_err       <= r_to | (m_rw & (!r_valid_s2 | (m_bytes == 5'd0)));
          r_gcnt        <= '0;
          r_state       <= S_GAP;
        end
        S_GAP: begin
          if (r_gcnt == GW'(GAP_CYCLES - 1)) r_state <= S_IDLE;
          else r_gcnt <= r_gcnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
